mult_share_sched: RTL and testbench

- Round-robin scheduler that time-shares one combinational signed multiplier among NUM_REQ requesters.
- The multiplier is a 6b x 8b EGFET multiplier, exact or approximate. It sits outside this block: this block drives its operands and captures its product.
- Each requester uses a valid/ready handshake. Results return through a single-entry output register tagged with the requester id.
- Lets several datapath lanes reuse one printed multiplier, saving area.

---
 rtl/mult_share_sched.sv | 145 ++++++++++++++
 tb/tb_mult_share_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler time-sharing one external
// combinational signed multiplier among NUM_REQ valid/ready requesters.
// Two-stage pipeline: OP drives the multiplier operands, RSP captures the
// product into a single-entry, id-tagged output register.
module mult_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int BIT_WIDTH  = 6,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = BIT_WIDTH + COEF_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*COEF_WIDTH-1:0]  req_b,
  output logic [BIT_WIDTH-1:0]           mul_a,
  output logic [COEF_WIDTH-1:0]          mul_b,
  input  logic [OUT_WIDTH-1:0]           mul_p,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [OUT_WIDTH-1:0]           rsp_data,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic                           busy
);

  // OP stage
  logic                  op_vld_q, op_vld_d;
  logic [BIT_WIDTH-1:0]  op_a_q,   op_a_d;
  logic [COEF_WIDTH-1:0] op_b_q,   op_b_d;
  logic [ID_WIDTH-1:0]   op_id_q,  op_id_d;

  // RSP stage
  logic                  rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0]  rsp_data_q,  rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q,    rsp_id_d;

  // Round-robin pointer: index where the next search starts
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  logic                  rsp_adv;
  logic                  op_free;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  accept;

  // Pipeline advance conditions
  always_comb begin
    rsp_adv = op_vld_q & (~rsp_valid_q | rsp_ready);
    op_free = ~op_vld_q | rsp_adv;
  end

  // Rotating priority search from ptr; NUM_REQ is a power of two so the
  // ID_WIDTH-bit sum wraps modulo NUM_REQ on its own
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + ID_WIDTH'(i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Single grant, gated by OP availability
  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = op_free;
    end
    accept = grant_found & op_free;
  end

  // Next-state for OP stage and pointer; operands hold while idle
  always_comb begin
    op_vld_d = op_vld_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_id_d  = op_id_q;
    ptr_d    = ptr_q;
    if (rsp_adv) begin
      op_vld_d = 1'b0;
    end
    if (accept) begin
      op_vld_d = 1'b1;
      op_a_d   = req_a[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
      op_b_d   = req_b[int'(grant_idx)*COEF_WIDTH +: COEF_WIDTH];
      op_id_d  = grant_idx;
      ptr_d    = grant_idx + ID_WIDTH'(1);
    end
  end

  // Next-state for RSP stage; product captured unmodified
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (rsp_adv) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mul_p;
      rsp_id_d    = op_id_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      op_vld_q    <= op_vld_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  // Output drive
  always_comb begin
    mul_a     = op_a_q;
    mul_b     = op_b_q;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    busy      = op_vld_q | rsp_valid_q;
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: directed and randomized checks of the shared
// multiplier scheduler, with an exact multiplier model on mul_p and a
// queue-based reference of in-flight requests.
module tb_mult_share_sched;
  localparam int N  = 4;
  localparam int BW = 6;
  localparam int CW = 8;
  localparam int OW = BW + CW;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*BW-1:0] req_a;
  logic [N*CW-1:0] req_b;
  logic [BW-1:0] mul_a;
  logic [CW-1:0] mul_b;
  logic [OW-1:0] mul_p;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [OW-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Exact signed multiplier
  logic signed [OW-1:0] ea, eb;
  assign ea    = $signed(mul_a);
  assign eb    = $signed(mul_b);
  assign mul_p = ea * eb;

  mult_share_sched #(
    .NUM_REQ(N), .BIT_WIDTH(BW), .COEF_WIDTH(CW), .OUT_WIDTH(OW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  // Reference: queue of accepted-but-undelivered requests, in order
  typedef struct { int id; int a; int b; int prod; } exp_t;
  exp_t exp_q[$];
  int   m_ptr;
  bit   m_last_acc;
  int   e_grant;
  bit   e_free;
  bit   e_rsp_valid;
  bit   e_op_vld;
  logic [N-1:0] e_ready;

  // Settle inputs, then derive expectations from the reference
  task automatic eval();
    #3;
    e_grant = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (e_grant < 0 && req_valid[j]) e_grant = j;
    end
    // two entries in flight fill both stages; OP frees only if RSP drains
    e_free      = (exp_q.size() < 2) || rsp_ready;
    e_ready     = '0;
    if (e_grant >= 0 && e_free) e_ready[e_grant] = 1'b1;
    // a lone entry accepted at the last edge is still in OP
    e_rsp_valid = (exp_q.size() == 2) || (exp_q.size() == 1 && !m_last_acc);
    e_op_vld    = (exp_q.size() == 2) || (exp_q.size() == 1 && m_last_acc);
  endtask

  // Apply the clock edge to the reference, then move past the edge
  task automatic advance();
    bit   acc;
    exp_t e;
    acc = (e_grant >= 0) && e_free;
    if (e_rsp_valid && rsp_ready) void'(exp_q.pop_front());
    if (acc) begin
      e.id   = e_grant;
      e.a    = $signed(req_a[e_grant*BW +: BW]);
      e.b    = $signed(req_b[e_grant*CW +: CW]);
      e.prod = e.a * e.b;
      exp_q.push_back(e);
      m_ptr  = (e_grant + 1) % N;
    end
    m_last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ptr      = 0;
    m_last_acc = 1'b0;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i*BW +: BW] = BW'($urandom);
      req_b[i*CW +: CW] = CW'($urandom);
    end
  endtask

  task automatic test_reset();
    do_reset();
    eval();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (mul_a !== '0 || mul_b !== '0) begin bad++; $display("FAIL reset_mul: got %h/%h want 0/0", mul_a, mul_b); end
    total++; if (rsp_data !== '0 || rsp_id !== '0) begin bad++; $display("FAIL reset_rsp: got %h/%h want 0/0", rsp_data, rsp_id); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_a[2*BW +: BW] = 6'h20;
    req_b[2*CW +: CW] = 8'h7f;
    rsp_ready = 1'b1;
    eval();
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    advance();
    req_valid = '0;
    eval();
    total++; if (mul_a !== 6'h20 || mul_b !== 8'h7f) begin bad++; $display("FAIL single_operands: got %h/%h want 20/7f", mul_a, mul_b); end
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_op_stage: got busy=%b rsp_valid=%b want 1/0", busy, rsp_valid); end
    advance();
    eval();
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 14'h3020 || rsp_id !== 2'd2) begin
      bad++; $display("FAIL single_rsp: got v=%b d=%h id=%0d want 1/3020/2", rsp_valid, rsp_data, rsp_id); end
    advance();
    eval();
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_extremes();
    logic [BW-1:0] ta [3];
    logic [CW-1:0] tb [3];
    logic [OW-1:0] tp [3];
    ta[0] = 6'h20; tb[0] = 8'h80; tp[0] = 14'd4096;
    ta[1] = 6'h1f; tb[1] = 8'h7f; tp[1] = 14'd3937;
    ta[2] = 6'h00; tb[2] = 8'h80; tp[2] = 14'd0;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      randomize_operands();
      req_valid = 4'b0010;
      req_a[1*BW +: BW] = ta[t];
      req_b[1*CW +: CW] = tb[t];
      rsp_ready = 1'b1;
      eval();
      advance();
      req_valid = '0;
      eval();
      advance();
      eval();
      total++; if (rsp_valid !== 1'b1 || rsp_data !== tp[t] || rsp_id !== 2'd1) begin
        bad++; $display("FAIL extreme_%0d: got v=%b d=%0d id=%0d want 1/%0d/1", t, rsp_valid, rsp_data, rsp_id, tp[t]); end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      randomize_operands();
      eval();
      want = '0;
      want[k % N] = 1'b1;
      total++; if (req_ready !== want) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, want); end
      if (k >= 2) begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== IW'((k - 2) % N) || rsp_data !== OW'(exp_q[0].prod)) begin
          bad++; $display("FAIL rr_rsp_%0d: got v=%b id=%0d d=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_data, (k - 2) % N, OW'(exp_q[0].prod)); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held_d;
    logic [IW-1:0] held_id;
    int            last_id;
    last_id = -1;
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 14; k++) begin
      randomize_operands();
      rsp_ready = !(k >= 4 && k < 7);
      eval();
      if (k == 4) begin held_d = rsp_data; held_id = rsp_id; end
      if (k > 4 && k < 7) begin
        total++; if (rsp_data !== held_d || rsp_id !== held_id) begin
          bad++; $display("FAIL bp_hold_%0d: got %h/%0d want %h/%0d", k, rsp_data, rsp_id, held_d, held_id); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_stall_%0d: got %b want 0000", k, req_ready); end
      end
      total++; if (req_ready !== e_ready || rsp_valid !== e_rsp_valid) begin
        bad++; $display("FAIL bp_ctrl_%0d: got rdy=%b v=%b want %b/%b", k, req_ready, rsp_valid, e_ready, e_rsp_valid); end
      if (rsp_valid && rsp_ready) begin
        total++; if (last_id >= 0 && int'(rsp_id) != (last_id + 1) % N) begin
          bad++; $display("FAIL bp_seq_%0d: got id %0d want %0d", k, rsp_id, (last_id + 1) % N); end
        last_id = rsp_id;
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    eval();
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_g3: got %b want 1000", req_ready); end
    advance();
    req_valid = 4'b0011;
    eval();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_g0: got %b want 0001", req_ready); end
    advance();
    eval();
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_g1: got %b want 0010", req_ready); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*BW +: BW] = 6'd5;
      req_b[i*CW +: CW] = 8'd3;
    end
    req_valid = '1;
    rsp_ready = 1'b0;
    eval(); advance();
    eval(); advance();
    eval();
    total++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_data !== 14'd15) begin
      bad++; $display("FAIL mid_loaded: got v=%b busy=%b d=%0d want 1/1/15", rsp_valid, busy, rsp_data); end
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== '0 || mul_a !== '0) begin
      bad++; $display("FAIL mid_async_clear: got v=%b busy=%b d=%h a=%h want 0/0/0/0", rsp_valid, busy, rsp_data, mul_a); end
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ptr      = 0;
    m_last_acc = 1'b0;
    eval();
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_first_grant: got %b want 0010", req_ready); end
    advance();
    req_valid = '0;
    eval(); advance();
    eval();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin bad++; $display("FAIL mid_first_rsp: got v=%b id=%0d want 1/1", rsp_valid, rsp_id); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      randomize_operands();
      eval();
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready_%0d: got %b want %b", k, req_ready, e_ready); end
      total++; if (rsp_valid !== e_rsp_valid || busy !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid_%0d: got v=%b busy=%b want %b/%b", k, rsp_valid, busy, e_rsp_valid, exp_q.size() != 0); end
      if (e_rsp_valid) begin
        total++; if (rsp_id !== IW'(exp_q[0].id) || rsp_data !== OW'(exp_q[0].prod)) begin
          bad++; $display("FAIL rnd_rsp_%0d: got %0d/%h want %0d/%h", k, rsp_id, rsp_data, exp_q[0].id, OW'(exp_q[0].prod)); end
      end
      if (e_op_vld) begin
        total++; if (mul_a !== BW'(exp_q[exp_q.size()-1].a) || mul_b !== CW'(exp_q[exp_q.size()-1].b)) begin
          bad++; $display("FAIL rnd_mul_%0d: got %h/%h want %h/%h", k, mul_a, mul_b, BW'(exp_q[exp_q.size()-1].a), CW'(exp_q[exp_q.size()-1].b)); end
      end
      advance();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin eval(); advance(); end
    eval();
    total++; if (busy !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got busy=%b left=%0d want 0/0", busy, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
